// File: rtl/burst_read_capture.sv
// Captures single-cycle RAM reads driven by the controller's cen/addr stream into a tagged FWFT FIFO.
// Optional feature: define BEAT_COUNT_EN to add the 16-bit beat_count pop counter output.
module burst_read_capture #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic                     start,
    input  logic [AW-1:0]            addr,
    output logic                     mem_ren,
    output logic [AW-1:0]            mem_addr,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [AW-1:0]            out_addr,
    output logic                     out_first,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fill_level,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     frame_err
`ifdef BEAT_COUNT_EN
    ,
    output logic [15:0]              beat_count
`endif
);

    localparam int PW = $clog2(DEPTH);

    logic            tag_v;
    logic [AW-1:0]   tag_addr;

    logic [DW-1:0]   data_mem [DEPTH];
    logic [AW-1:0]   addr_mem [DEPTH];
    logic [PW:0]     wr_ptr;
    logic [PW:0]     rd_ptr;
    logic [PW:0]     level;

    logic            full;
    logic            empty;
    logic            do_pop;
    logic            do_push;
    logic            drop;
    logic            frame_bad;

    assign mem_ren  = cen;
    assign mem_addr = addr;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (PW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = !empty && out_ready;
    assign do_push = tag_v && (!full || do_pop);
    assign drop    = tag_v && full && !do_pop;

    // A burst marker belongs only on the beat whose low address bits are 01.
    assign frame_bad = (cen && (start != (addr[1:0] == 2'b01))) || (start && !cen);

    assign out_valid  = !empty;
    assign out_data   = data_mem[rd_ptr[PW-1:0]];
    assign out_addr   = addr_mem[rd_ptr[PW-1:0]];
    assign out_first  = (out_addr[1:0] == 2'b00);
    assign out_last   = (out_addr[1:0] == 2'b11);
    assign fill_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v    <= 1'b0;
            tag_addr <= '0;
        end else begin
            tag_v    <= cen;
            tag_addr <= cen ? addr : tag_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            data_mem[wr_ptr[PW-1:0]] <= mem_rdata;
            addr_mem[wr_ptr[PW-1:0]] <= tag_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Set events take priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (frame_bad) begin
                frame_err <= 1'b1;
            end else if (err_clr) begin
                frame_err <= 1'b0;
            end
        end
    end

`ifdef BEAT_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_count <= '0;
        end else if (do_pop) begin
            beat_count <= beat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_burst_read_capture.sv
// Scoreboard bench for burst_read_capture: stimulus queues issued reads, a monitor replays them
// through a queue-level FIFO model and compares every cycle.
module tb_burst_read_capture;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            cen;
    logic            start;
    logic [AW-1:0]   addr;
    logic            mem_ren;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [AW-1:0]   out_addr;
    logic            out_first;
    logic            out_last;
    logic [3:0]      fill_level;
    logic            err_clr;
    logic            overflow;
    logic            frame_err;
`ifdef BEAT_COUNT_EN
    logic [15:0]     beat_count;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         issued[$];
    beat_t         model_q[$];
    logic [DW-1:0] ram [1024];

    int total = 0;
    int bad   = 0;

    burst_read_capture #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
`ifdef BEAT_COUNT_EN
        .beat_count (beat_count),
`endif
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .start      (start),
        .addr       (addr),
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_first  (out_first),
        .out_last   (out_last),
        .fill_level (fill_level),
        .err_clr    (err_clr),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic s, input logic [AW-1:0] a,
                                 input logic rdy, input logic clr);
        beat_t b;
        @(negedge clk);
        cen       = c;
        start     = s;
        addr      = a;
        out_ready = rdy;
        err_clr   = clr;
        if (c) begin
            b.a = a;
            b.d = ram[a];
            issued.push_back(b);
        end
    endtask

    task automatic sendBeat(input logic [AW-1:0] a, input logic rdy);
        applyStimulus(1'b1, (a[1:0] == 2'b01), a, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, '0, rdy, 1'b0);
        end
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst     = 1'b1;
        cen     = 1'b0;
        start   = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples mid-low-phase, compares against the model, then advances the model
    // across the coming rising edge.
    initial begin : monitor
        logic          pend_v;
        beat_t         pend;
        beat_t         head;
        logic          m_ovf;
        logic          m_fe;
        logic [15:0]   m_beats;
        logic          pop;
        logic          full;
        logic          ovf_set;
        logic          fe_set;
        pend_v  = 1'b0;
        m_ovf   = 1'b0;
        m_fe    = 1'b0;
        m_beats = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                model_q.delete();
                pend_v  = 1'b0;
                m_ovf   = 1'b0;
                m_fe    = 1'b0;
                m_beats = '0;
                if (cen && issued.size() != 0) begin
                    pend = issued.pop_front();
                end
                checkOutput("rst_valid", out_valid, 0);
                checkOutput("rst_fill", fill_level, 0);
                checkOutput("rst_overflow", overflow, 0);
                checkOutput("rst_frame_err", frame_err, 0);
                continue;
            end
            checkOutput("valid", out_valid, model_q.size() != 0);
            checkOutput("fill", fill_level, model_q.size());
            checkOutput("overflow", overflow, m_ovf);
            checkOutput("frame_err", frame_err, m_fe);
`ifdef BEAT_COUNT_EN
            checkOutput("beat_count", beat_count, m_beats);
`endif
            if (model_q.size() != 0) begin
                head = model_q[0];
                checkOutput("data", out_data, head.d);
                checkOutput("addr", out_addr, head.a);
                checkOutput("first", out_first, head.a[1:0] == 2'b00);
                checkOutput("last", out_last, head.a[1:0] == 2'b11);
            end

            pop     = (model_q.size() != 0) && out_ready;
            full    = (model_q.size() == DEPTH);
            ovf_set = pend_v && full && !pop;
            if (pop) begin
                head = model_q.pop_front();
                m_beats = m_beats + 16'd1;
            end
            if (pend_v && !ovf_set) begin
                model_q.push_back(pend);
            end
            fe_set = (cen && (start != (addr[1:0] == 2'b01))) || (start && !cen);
            if (ovf_set) m_ovf = 1'b1;
            else if (err_clr) m_ovf = 1'b0;
            if (fe_set) m_fe = 1'b1;
            else if (err_clr) m_fe = 1'b0;
            pend_v = cen;
            if (cen) begin
                if (issued.size() != 0) begin
                    pend = issued.pop_front();
                end else begin
                    bad++;
                    total++;
                    $display("[TB] FAIL issued_queue: got empty expected a pending beat");
                    pend_v = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] ra;
        logic          c;
        logic          s;
        logic          rdy;
        logic          clr;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = $urandom();
        end
        for (int i = 0; i < 4; i++) begin
            ram[i] = 32'hA0 + i;
        end
        rst       = 1'b1;
        cen       = 1'b0;
        start     = 1'b0;
        addr      = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic burst");
        for (int i = 0; i < 4; i++) sendBeat(AW'(i), 1'b1);
        idle(6, 1'b1);

        $display("[TB] overflow on 9 beats");
        for (int i = 0; i < 9; i++) sendBeat(AW'(i), 1'b0);
        idle(2, 1'b0);
        idle(12, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);

        $display("[TB] full with simultaneous pop");
        for (int i = 16; i < 24; i++) sendBeat(AW'(i), 1'b0);
        idle(2, 1'b0);
        for (int i = 24; i < 44; i++) sendBeat(AW'(i), 1'b1);
        idle(12, 1'b1);

        $display("[TB] frame errors");
        applyStimulus(1'b1, 1'b1, 10'h002, 1'b1, 1'b0);
        idle(2, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);
        applyStimulus(1'b0, 1'b1, '0, 1'b1, 1'b1);
        idle(2, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1);
        idle(2, 1'b1);

        $display("[TB] reset mid-burst");
        for (int i = 40; i < 44; i++) sendBeat(AW'(i), 1'b0);
        pulseReset();
        idle(6, 1'b1);

        $display("[TB] randomized traffic");
        ra = 10'h3F0;
        for (int i = 0; i < 500; i++) begin
            c   = ($urandom_range(0, 3) != 0);
            s   = c ? (ra[1:0] == 2'b01) : 1'b0;
            if ($urandom_range(0, 39) == 0) s = ~s;
            rdy = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 29) == 0);
            applyStimulus(c, s, ra, rdy, clr);
            if (c) ra = ra + 1'b1;
        end
        idle(12, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
